// File: rtl/btn_pkg.sv
// Shared constants and types for the button conditioner.
// Stuck detection is compiled in only when BTN_STUCK_DETECT_EN is defined.
package btn_pkg;

  localparam int NUM_BTN          = 8;
  localparam int DB_CYCLES_DEF    = 16;
  localparam int STUCK_CYCLES_DEF = 20000;
  localparam int HOLD_W           = 16;

  // What the debounce counter decided on this cycle.
  typedef enum logic [1:0] {
    COMMIT_NONE,
    COMMIT_RISE,
    COMMIT_FALL
  } commit_t;

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: 2-flop synchronizer, debounce counter, level, press/release pulses
// and, with BTN_STUCK_DETECT_EN defined, a saturating hold counter driving stuck.
module btn_debounce_bit
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef BTN_STUCK_DETECT_EN
  , parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic enable,
  output logic level,
  output logic press,
  output logic rel,
  output logic stuck
);

  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  commit_t          commit;

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    commit = COMMIT_NONE;
    if ((s2 != level) && (cnt == CNT_LAST)) begin
      commit = s2 ? COMMIT_RISE : COMMIT_FALL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      // Enable only masks the pulses; the level keeps tracking and edges are not replayed.
      press <= enable && (commit == COMMIT_RISE);
      rel   <= enable && (commit == COMMIT_FALL);
      if (s2 == level) begin
        cnt <= '0;
      end else if (commit != COMMIT_NONE) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_STUCK_DETECT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(STUCK_CYCLES);

  logic [HOLD_W-1:0] hold;
  logic              level_next;

  // Looking at the next level lets stuck drop on the same edge that clears the level.
  assign level_next = (commit == COMMIT_RISE) || (level && (commit != COMMIT_FALL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      stuck <= 1'b0;
    end else begin
      if (!level) begin
        hold <= '0;
      end else if (hold != '1) begin
        hold <= hold + 1'b1;
      end
      stuck <= level_next && (hold >= HOLD_LIM);
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Eight independent debounced buttons with gated press/release pulses.
// Define BTN_STUCK_DETECT_EN to compile in per-button stuck detection.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic [NUM_BTN-1:0] stuck
);

  if ((DB_CYCLES < 2) || (DB_CYCLES > 65535) ||
      (STUCK_CYCLES < 1) || (STUCK_CYCLES > 65535)) begin : g_param_err
    $error("btn_conditioner: DB_CYCLES or STUCK_CYCLES out of range");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_bit #(
      .DB_CYCLES    (DB_CYCLES)
`ifdef BTN_STUCK_DETECT_EN
      , .STUCK_CYCLES (STUCK_CYCLES)
`endif
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_raw[i]),
      .enable (enable),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .stuck  (stuck[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected pulses are queued with their due
// cycle when stimulus is driven and matched against the pulses the DUT produces.
module tb_btn_conditioner;

  localparam int DB  = 16;
  localparam int ST  = 100;
  localparam int LAT = DB + 2;
`ifdef BTN_STUCK_DETECT_EN
  localparam int STK = 1;
`else
  localparam int STK = 0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic [7:0] btn_raw = '0;
  logic [7:0] btn_level;
  logic [7:0] btn_press;
  logic [7:0] btn_release;
  logic       any_press;
  logic [7:0] stuck;

  btn_conditioner #(
    .DB_CYCLES    (DB),
    .STUCK_CYCLES (ST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press),
    .stuck       (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit rel;
    int idx;
  } evt_t;

  evt_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_evt(bit rel, int idx, int at);
    evt_t e;
    e.cyc = at;
    e.rel = rel;
    e.idx = idx;
    sb.push_back(e);
  endtask

  // Change one raw input at a negedge; queue the pulse it must cause LAT edges later.
  task automatic drive(int idx, bit v, bit pulse);
    btn_raw[idx] = v;
    if (pulse) expect_evt(!v, idx, cyc + LAT);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic match(bit rel, int idx);
    int    k;
    string tag;
    k   = -1;
    tag = $sformatf("%s%0d", rel ? "release" : "press", idx);
    for (int j = 0; j < sb.size(); j++) begin
      if (k < 0 && sb[j].rel == rel && sb[j].idx == idx) k = j;
    end
    if (k >= 0) begin
      check(tag, cyc, sb[k].cyc);
      sb.delete(k);
    end else begin
      check({tag, "_unexpected"}, cyc, -1);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  bit exp_any;
  always @(negedge clk) begin
    exp_any = 1'b0;
    foreach (sb[k]) if (sb[k].cyc == cyc && !sb[k].rel) exp_any = 1'b1;
    if (exp_any || any_press) check("any_press", any_press, exp_any);
    for (int i = 0; i < 8; i++) begin
      if (btn_press[i])   match(1'b0, i);
      if (btn_release[i]) match(1'b1, i);
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc < cyc) begin
        check($sformatf("missed_%s%0d", sb[k].rel ? "release" : "press", sb[k].idx),
              cyc, sb[k].cyc);
        sb.delete(k);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int l;

    // Reset with every raw input high: nothing may leak through.
    rst_n   = 1'b0;
    enable  = 1'b0;
    btn_raw = 8'hff;
    step(3);
    check("rst_level",   btn_level,   0);
    check("rst_press",   btn_press,   0);
    check("rst_release", btn_release, 0);
    check("rst_any",     any_press,   0);
    check("rst_stuck",   stuck,       0);
    btn_raw = '0;
    step(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(5);

    // Clean press on bit 3 held 40 cycles: level rises exactly LAT edges later.
    drive(3, 1'b1, 1'b1);
    c = cyc;
    wait_cyc(c + LAT - 1);
    check("lvl3_early", btn_level[3], 0);
    wait_cyc(c + LAT);
    check("lvl3_rise", btn_level[3], 1);
    wait_cyc(c + 40);
    drive(3, 1'b0, 1'b1);
    step(LAT + 5);

    // Bounce on bit 0 every 5 cycles, then a stable press.
    for (int k = 0; k < 6; k++) begin
      drive(0, ~btn_raw[0], 1'b0);
      step(5);
    end
    drive(0, 1'b1, 1'b1);
    step(LAT + 3);
    check("lvl0_settled", btn_level[0], 1);
    drive(0, 1'b0, 1'b1);
    step(LAT + 3);

    // Bit 5: 15-cycle pulse is rejected, 16-cycle pulse is accepted.
    drive(5, 1'b1, 1'b0);
    step(15);
    drive(5, 1'b0, 1'b0);
    step(LAT + 3);
    check("lvl5_short", btn_level[5], 0);
    drive(5, 1'b1, 1'b1);
    step(16);
    drive(5, 1'b0, 1'b1);
    step(LAT + 3);
    check("lvl5_after", btn_level[5], 0);

    // Bit 1: press while disabled is tracked silently; release after enabling pulses.
    enable = 1'b0;
    drive(1, 1'b1, 1'b0);
    step(LAT + 3);
    check("lvl1_disabled", btn_level[1], 1);
    enable = 1'b1;
    drive(1, 1'b0, 1'b1);
    step(LAT + 3);
    check("lvl1_released", btn_level[1], 0);

    // Reset mid-debounce on bit 2 while bit 4 is already down.
    drive(4, 1'b1, 1'b1);
    step(LAT + 3);
    check("lvl4_pre_rst", btn_level[4], 1);
    drive(2, 1'b1, 1'b0);
    step(8);
    rst_n = 1'b0;
    step(2);
    check("mid_rst_level",   btn_level,   0);
    check("mid_rst_press",   btn_press,   0);
    check("mid_rst_release", btn_release, 0);
    check("mid_rst_stuck",   stuck,       0);
    rst_n = 1'b1;
    expect_evt(1'b0, 2, cyc + LAT);
    expect_evt(1'b0, 4, cyc + LAT);
    step(LAT + 3);
    check("lvl_post_rst", btn_level, 8'h14);
    drive(2, 1'b0, 1'b1);
    drive(4, 1'b0, 1'b1);
    step(LAT + 3);

    // Bit 6 held 150 cycles: stuck rises ST+1 edges after the level and falls with it.
    drive(6, 1'b1, 1'b1);
    c = cyc;
    l = c + LAT;
    wait_cyc(l + ST);
    check("stuck6_early", stuck[6], 0);
    wait_cyc(l + ST + 1);
    check("stuck6_rise", stuck[6], STK);
    check("stuck_others", stuck & 8'hbf, 0);
    wait_cyc(c + 150);
    drive(6, 1'b0, 1'b1);
    wait_cyc(c + 150 + LAT - 1);
    check("stuck6_hold", stuck[6], STK);
    wait_cyc(c + 150 + LAT);
    check("stuck6_fall", stuck[6], 0);
    check("lvl6_fall", btn_level[6], 0);

    step(10);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL take parameter DB_CYCLES, default 16: debounce stability window in clk cycles, legal range 2..65535.
REQ-002 The block SHALL take parameter STUCK_CYCLES, default 20000: hold time before a button is flagged stuck, legal range 1..65535.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 btn_raw  in  8  asynchronous raw button inputs, active-high.
REQ-006 enable  in  1  game active; gates the pulse outputs only.
REQ-007 btn_level  out  8  debounced button level.
REQ-008 btn_press  out  8  one-cycle pulse on each debounced rising edge.
REQ-009 btn_release  out  8  one-cycle pulse on each debounced falling edge.
REQ-010 any_press  out  1  OR of btn_press.
REQ-011 stuck  out  8  per-button held-too-long flag, intended for downstream lockout.

Function
REQ-012 Each bit SHALL pass through a 2-flop synchronizer; s2 denotes the second stage.
REQ-013 Each bit SHALL have its own debounce counter, cleared on any cycle where s2 equals btn_level.
REQ-014 The counter SHALL increment on each cycle where s2 differs from btn_level.
REQ-015 When s2 differs from btn_level and the counter equals DB_CYCLES-1, btn_level SHALL take s2 and the counter SHALL clear.
REQ-016 Total latency from a stable btn_raw change to the btn_level change SHALL be DB_CYCLES+2 clk edges.
REQ-017 An s2 disagreement lasting fewer than DB_CYCLES consecutive cycles SHALL leave btn_level unchanged.
REQ-018 btn_press[i] SHALL be registered and high only in the cycle btn_level[i] first reads 1, and only if enable is 1 at the edge that sets btn_level[i].
REQ-019 btn_release[i] SHALL be registered and high only in the cycle btn_level[i] first reads 0, and only if enable is 1 at the edge that clears btn_level[i].
REQ-020 Synchronizers, counters and btn_level SHALL continue tracking while enable is 0; the missed edge SHALL NOT be replayed.
REQ-021 All eight bits SHALL be fully independent; simultaneous edges SHALL produce simultaneous pulses.
REQ-022 any_press SHALL be combinational from the btn_press registers, with no added latency.
REQ-023 Counter width SHALL be $clog2(DB_CYCLES); the counter SHALL never wrap, given REQ-015.

Reset
REQ-024 While rst_n is low, the synchronizers, counters, btn_level, btn_press, btn_release, stuck and hold counters SHALL all be 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count.
REQ-026 A button held through reset deassertion SHALL produce btn_level=1 and one btn_press, subject to enable, DB_CYCLES+2 cycles after deassertion.

Configuration
REQ-027 Macro BTN_STUCK_DETECT_EN SHALL compile in stuck detection.
REQ-028 With BTN_STUCK_DETECT_EN defined, each bit SHALL have a 16-bit saturating hold counter that increments while btn_level is 1 and clears while it is 0.
REQ-029 With BTN_STUCK_DETECT_EN defined, stuck[i] SHALL rise on the cycle after btn_level[i] has read 1 for STUCK_CYCLES consecutive cycles.
REQ-030 With BTN_STUCK_DETECT_EN defined, stuck[i] SHALL fall in the same cycle btn_level[i] reads 0, and SHALL ignore enable.
REQ-031 Without BTN_STUCK_DETECT_EN, stuck SHALL be constant 0 and no hold counters SHALL exist.

Structure
REQ-032 Shared package btn_pkg SHALL hold NUM_BTN=8, DB_CYCLES_DEF=16 and STUCK_CYCLES_DEF=20000.
REQ-033 Sub-module btn_debounce_bit SHALL contain one bit's synchronizer, debounce counter, level, press/release registers and the optional hold counter.
REQ-034 btn_debounce_bit SHALL be instantiated NUM_BTN times through a generate loop.

Verification (DB_CYCLES=16, STUCK_CYCLES=100)
REQ-035 enable=1, btn_raw[3] 0->1 held 40 cycles -> btn_level[3] rises 18 cycles later; btn_press[3] and any_press high for exactly that one cycle.
REQ-036 btn_raw[0] toggles every 5 cycles for 30 cycles, then held 1 -> exactly one btn_press[0], 18 cycles after the final edge.
REQ-037 btn_raw[5] high for 15 cycles (s2 high 15 cycles) -> no level change and no pulse; repeated at 16 cycles -> one btn_press[5] then one btn_release[5].
REQ-038 enable=0, press btn_raw[1], then set enable=1 and release -> btn_level[1] rises with no btn_press; btn_release[1] fires 18 cycles after the release.
REQ-039 Assert rst_n mid-debounce with btn_raw[2]=1 held -> all outputs 0 during reset; one btn_press[2] 18 cycles after deassertion.
REQ-040 BTN_STUCK_DETECT_EN defined, btn_raw[6] held 150 cycles -> stuck[6] rises 101 cycles after btn_level[6] rises and falls with btn_level[6]; macro undefined -> stuck stays 0.
